// File: rtl/fifo_sync_ram_fwft_pkg.sv
// Shared definitions for the RAM-backed FWFT FIFO.
//   FIFO_RAM_GENERIC / FIFO_RAM_SKY130 : storage back-end selector strings
//   fifo_clog2()                       : ceiling log2 for constant sizing
package fifo_sync_ram_fwft_pkg;

    localparam string FIFO_RAM_GENERIC = "GENERIC";
    localparam string FIFO_RAM_SKY130  = "SKY130";

    function automatic int fifo_clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/fifo_sync_ram_fwft_if.sv
// Handshake bundle between a FIFO user (master) and the FIFO (slave).
//   wr_data/wr_ena/wr_full  : push side
//   rd_data/rd_ena/rd_empty : pop side (rd_data valid while rd_empty=0)
//   level, almost_full/almost_empty : fill status
//   overflow/underflow, err_clr     : sticky error flags and their clear
interface fifo_sync_ram_fwft_if #(
    parameter int WIDTH  = 32,
    parameter int AWIDTH = 8
);
    logic [WIDTH-1:0] wr_data;
    logic             wr_ena;
    logic             wr_full;
    logic [WIDTH-1:0] rd_data;
    logic             rd_ena;
    logic             rd_empty;
    logic [AWIDTH:0]  level;
    logic             almost_full;
    logic             almost_empty;
    logic             overflow;
    logic             underflow;
    logic             err_clr;

    modport master (
        output wr_data, wr_ena, rd_ena, err_clr,
        input  wr_full, rd_data, rd_empty, level,
               almost_full, almost_empty, overflow, underflow
    );

    modport slave (
        input  wr_data, wr_ena, rd_ena, err_clr,
        output wr_full, rd_data, rd_empty, level,
               almost_full, almost_empty, overflow, underflow
    );
endinterface

// File: rtl/fifo_sync_ram_fwft_ram_sdp_reg.sv
// Simple-dual-port RAM, one write port, one registered read port.
//   clk     : clock
//   we_i    : write enable; waddr_i / wdata_i : write address / data
//   raddr_i : read address, sampled every cycle
//   rdata_o : word at raddr_i as of the previous edge
// A read and write of the same address on one edge returns the old word.
module ram_sdp_reg #(
    parameter int WIDTH  = 32,
    parameter int AWIDTH = 8
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [AWIDTH-1:0] waddr_i,
    input  logic [WIDTH-1:0]  wdata_i,
    input  logic [AWIDTH-1:0] raddr_i,
    output logic [WIDTH-1:0]  rdata_o
);
    localparam int DEPTH = 1 << AWIDTH;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/sky130_sram_1kbyte_1rw1r_32x256_8.sv
// Behavioural model of the OpenRAM sky130 1rw1r 32x256 macro, used for
// simulation and lint; the physical flow swaps in the hard macro.
//   port 0 (rw): clk0, csb0 (select, low), web0 (write, low), wmask0, addr0, din0, dout0
//   port 1 (r) : clk1, csb1 (select, low), addr1, dout1
module sky130_sram_1kbyte_1rw1r_32x256_8 (
    input  logic        clk0,
    input  logic        csb0,
    input  logic        web0,
    input  logic [3:0]  wmask0,
    input  logic [7:0]  addr0,
    input  logic [31:0] din0,
    output logic [31:0] dout0,
    input  logic        clk1,
    input  logic        csb1,
    input  logic [7:0]  addr1,
    output logic [31:0] dout1
);
    logic [31:0] mem_q [256];
    logic [31:0] dout0_q, dout1_q;

    always_ff @(posedge clk0) begin
        if (!csb0 && !web0) begin
            for (int b = 0; b < 4; b++)
                if (wmask0[b]) mem_q[addr0][b*8 +: 8] <= din0[b*8 +: 8];
        end
        if (!csb0 && web0) dout0_q <= mem_q[addr0];
    end

    always_ff @(posedge clk1) begin
        if (!csb1) dout1_q <= mem_q[addr1];
    end

    assign dout0 = dout0_q;
    assign dout1 = dout1_q;
endmodule

// File: rtl/fifo_sync_ram_fwft.sv
// First-word-fall-through synchronous FIFO over a registered-read SDP RAM.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of fifo_sync_ram_fwft_if (push/pop handshakes,
//              level, almost flags, sticky overflow/underflow, err_clr)
// The head word is shown straight from the RAM read register, so its slot
// stays allocated until popped; capacity is exactly DEPTH words.
module fifo_sync_ram_fwft
    import fifo_sync_ram_fwft_pkg::*;
#(
    parameter int    WIDTH     = 32,
    parameter int    AWIDTH    = 8,
    parameter int    AF_THRESH = (1 << AWIDTH) - 4,
    parameter int    AE_THRESH = 3,
    parameter string RAM_IMPL  = FIFO_RAM_GENERIC
) (
    input  logic                 clk,
    input  logic                 rst,
    fifo_sync_ram_fwft_if.slave  bus
);
    localparam int DEPTH = 1 << AWIDTH;
    localparam int LW    = fifo_clog2(DEPTH) + 1;

    localparam logic [LW-1:0]     DEPTH_L = LW'(DEPTH);
    localparam logic [LW-1:0]     AF_L    = LW'(AF_THRESH);
    localparam logic [LW-1:0]     AE_L    = LW'(AE_THRESH);
    localparam logic [AWIDTH-1:0] RD_RST  = AWIDTH'(DEPTH - 1);

    logic [AWIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [AWIDTH-1:0] rd_addr_q, rd_addr_nxt;
    // Unread RAM words minus one; MSB set means nothing left to prefetch.
    logic [LW-1:0]     cnt_q, cnt_d;
    logic [LW-1:0]     level_q, level_d;
    logic              head_vld_q, head_vld_d;
    logic              af_q, af_d, ae_q, ae_d;
    logic              ovf_q, ovf_d, unf_q, unf_d;

    logic wr_full, push_acc, pop_acc, ram_rd_ena;
    logic [WIDTH-1:0] ram_dout;

    assign wr_full    = (level_q == DEPTH_L);
    assign push_acc   = bus.wr_ena & ~wr_full;
    assign pop_acc    = bus.rd_ena & head_vld_q;
    // Fetch the next word whenever the head slot is being freed or empty.
    assign ram_rd_ena = (pop_acc | ~head_vld_q) & ~cnt_q[LW-1];

    always_comb begin
        wr_addr_d   = wr_addr_q + AWIDTH'(push_acc);
        rd_addr_nxt = rd_addr_q + AWIDTH'(ram_rd_ena);
        cnt_d       = cnt_q + LW'(push_acc) - LW'(ram_rd_ena);
        level_d     = level_q + LW'(push_acc) - LW'(pop_acc);
        head_vld_d  = ram_rd_ena | (head_vld_q & ~pop_acc);
        af_d        = (level_d >= AF_L);
        ae_d        = (level_d <= AE_L);
        // New error wins over a simultaneous clear.
        ovf_d       = (bus.wr_ena & wr_full) | (ovf_q & ~bus.err_clr);
        unf_d       = (bus.rd_ena & ~head_vld_q) | (unf_q & ~bus.err_clr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_addr_q  <= '0;
            rd_addr_q  <= RD_RST;
            cnt_q      <= '1;
            level_q    <= '0;
            head_vld_q <= 1'b0;
            af_q       <= (AF_THRESH == 0);
            ae_q       <= 1'b1;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            wr_addr_q  <= wr_addr_d;
            rd_addr_q  <= rd_addr_nxt;
            cnt_q      <= cnt_d;
            level_q    <= level_d;
            head_vld_q <= head_vld_d;
            af_q       <= af_d;
            ae_q       <= ae_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
        end
    end

    // Read address is presented every cycle; while stalled it repeats the
    // head address so rd_data holds.
    if (RAM_IMPL == FIFO_RAM_SKY130) begin : g_sky130
        if (WIDTH != 32 || AWIDTH != 8) begin : g_bad_cfg
            $error("SKY130 back-end requires WIDTH=32 and AWIDTH=8");
        end
        logic [31:0] port0_dout;
        sky130_sram_1kbyte_1rw1r_32x256_8 u_ram (
            .clk0   (clk),
            .csb0   (~push_acc),
            .web0   (~push_acc),
            .wmask0 (4'hF),
            .addr0  (wr_addr_q),
            .din0   (bus.wr_data),
            .dout0  (port0_dout),
            .clk1   (clk),
            .csb1   (1'b0),
            .addr1  (rd_addr_nxt),
            .dout1  (ram_dout)
        );
    end else if (RAM_IMPL == FIFO_RAM_GENERIC) begin : g_generic
        ram_sdp_reg #(.WIDTH(WIDTH), .AWIDTH(AWIDTH)) u_ram (
            .clk     (clk),
            .we_i    (push_acc),
            .waddr_i (wr_addr_q),
            .wdata_i (bus.wr_data),
            .raddr_i (rd_addr_nxt),
            .rdata_o (ram_dout)
        );
    end else begin : g_bad_impl
        $error("Unknown RAM_IMPL");
    end

    assign bus.wr_full      = wr_full;
    assign bus.rd_data      = ram_dout;
    assign bus.rd_empty     = ~head_vld_q;
    assign bus.level        = level_q;
    assign bus.almost_full  = af_q;
    assign bus.almost_empty = ae_q;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = unf_q;
endmodule

// File: doc/fifo_sync_ram_fwft.md
# fifo_sync_ram_fwft

Parametrised synchronous first-word-fall-through FIFO built around a simple-dual-port RAM with a registered read port. It generalises the fixed 256×32 sky130 FIFO:
- width and depth are parameters;
- the storage back-end is selectable (generic inferred RAM or the sky130 OpenRAM macro);
- it adds a fill-level output, almost-full/almost-empty flags and sticky overflow/underflow error flags.

It sits between the Wishbone/DMA datapaths and bursty consumers (audio, USB, SPI engines) in the same clock domain.

## Interface
Parameters:
- WIDTH, 32, data width in bits (1..64).
- AWIDTH, 8, address width; DEPTH = 2**AWIDTH words (2..12).
- AF_THRESH, DEPTH-4, almost_full asserted when level >= AF_THRESH.
- AE_THRESH, 3, almost_empty asserted when level <= AE_THRESH.
- RAM_IMPL, "GENERIC", storage back-end:
  - "GENERIC": behavioural RAM.
  - "SKY130": sky130_sram_1kbyte_1rw1r_32x256_8; legal only with WIDTH=32, AWIDTH=8, otherwise elaboration error.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- wr_data  in  WIDTH  push data.
- wr_ena  in  1  push request.
- wr_full  out  1  FIFO holds DEPTH words.
- rd_data  out  WIDTH  head word; valid when rd_empty=0.
- rd_ena  in  1  pop request (acknowledges rd_data).
- rd_empty  out  1  no word presented.
- level  out  AWIDTH+1  words stored, including the presented head (0..DEPTH).
- almost_full  out  1  registered threshold flag.
- almost_empty  out  1  registered threshold flag.
- overflow  out  1  sticky: push attempted while wr_full.
- underflow  out  1  sticky: pop attempted while rd_empty.
- err_clr  in  1  clears overflow/underflow.

## Operation
- Capacity is exactly DEPTH words. The head word is read from RAM and never copied out, so its slot stays reserved until it is popped.
- Accepted push: `wr_ena & ~wr_full`. Writes RAM[wr_addr], then wr_addr+1 (mod DEPTH).
- Push while wr_full is dropped, even with a simultaneous pop. It sets overflow and leaves RAM and pointers untouched.
- Accepted pop: `rd_ena & ~rd_empty`. Pop while rd_empty is ignored and sets underflow.
- Read port address is rd_addr_nxt = rd_addr + ram_rd_ena, presented every cycle. Re-reading the same address while stalled keeps rd_data stable.
- Prefetch: ram_rd_ena = (accepted pop | ~head_valid) & (RAM holds an unread word).
- Internal count of unread RAM words uses the "count−1" encoding: the MSB set means none.
- level: +1 on accepted push, −1 on accepted pop; both in the same cycle leaves it unchanged.
- wr_full = (level == DEPTH).
- almost_full and almost_empty are registered from the next-state level. They are exact in the same cycle as level.
- overflow/underflow set on the offending cycle and hold until err_clr. If err_clr and a new error occur together, the set wins.
- Pointer wrap is modulo DEPTH. Level arithmetic is AWIDTH+1 bits and never wraps.

## Timing
- Reset values:
  - rd_empty=1, wr_full=0, level=0;
  - almost_empty=1, almost_full=(AF_THRESH==0);
  - overflow=0, underflow=0;
  - wr_addr=0, rd_addr=DEPTH−1;
  - rd_data is undefined while rd_empty=1.
- Push sampled at edge E into an empty FIFO:
  - level=1 after E;
  - rd_empty=0 and rd_data valid after E+1.
- Pop sampled at edge E: the next word is on rd_data after E with no bubble, provided it was written at or before edge E−1.
- Sustained throughput is 1 push + 1 pop per cycle.
- wr_full rises after the edge that accepts word DEPTH. It falls after the edge of the first accepted pop.
- Reset mid-operation discards all content immediately. Outputs take reset values asynchronously.

## Structure
- Shared package/header: FIFO_RAM_GENERIC / FIFO_RAM_SKY130 selector constants and a clog2 helper.
- Sub-module ram_sdp_reg (WIDTH, AWIDTH):
  - one write port and one registered read port;
  - same-address read/write returns old data;
  - the generate branch instantiates either this module or the sky130 macro.
- The top level holds only the pointers, counters and flags.

## Test plan
- Reset, then push 0xA5A5_0001 at edge 0 → level=1 after edge 0; rd_empty=0 and rd_data=0xA5A5_0001 after edge 1.
- Fill 256 words (0..255), no pops:
  - wr_full=1 after the 256th push;
  - a 257th push sets overflow, level stays 256;
  - draining gives 0..255 in order.
- Simultaneous push/pop every cycle for 1000 cycles at level 5 → level constant at 5, data in order, no flags.
- Pop on empty → underflow=1, level=0; err_clr pulse → underflow=0.
- AF_THRESH=252, AE_THRESH=3:
  - almost_full rises exactly when level reaches 252;
  - almost_empty falls when level reaches 4.
- Assert rst while level=100 and rd_ena active → all outputs at reset values; the next push/pop sequence behaves as from cold reset.
